msrv32_pc_pipe_reg: RTL and testbench
=====================================

MSRV32_PC_PIPE_REG -- requirements
Module: msrv32_pc_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of every PC data path.
REQ-002 Parameter DEPTH, default 2, legal range 1..8, SHALL set the number of register stages.
REQ-003 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the value loaded into every stage data register on reset.
REQ-004 ms_riscv32_mp_clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 ms_riscv32_mp_rst_n_in  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 pc_mux_in  input  DATA_W  SHALL carry the upstream PC beat.
REQ-007 pc_valid_in  input  1  SHALL mark pc_mux_in as valid.
REQ-008 pc_ready_out  output  1  SHALL indicate stage 0 accepts a beat this cycle.
REQ-009 pc_ready_in  input  1  SHALL indicate the downstream consumer accepts the output beat.
REQ-010 stall_in  input  1  SHALL be a global hold request.
REQ-011 flush_in  input  1  SHALL be a pipeline-kill request.
REQ-012 pc_out  output  DATA_W  SHALL be the last-stage data register.
REQ-013 pc_valid_out  output  1  SHALL be the last-stage valid bit.
REQ-014 pc_count_out  output  $clog2(DEPTH+1)  SHALL report the number of valid stages.

Function
REQ-015 Each stage i SHALL hold data[i] and vld[i]; stage DEPTH-1 drives pc_out and pc_valid_out.
REQ-016 Effective downstream ready SHALL be rdy_eff = pc_ready_in AND NOT stall_in.
REQ-017 Stage advance SHALL be adv[DEPTH-1] = NOT vld[DEPTH-1] OR rdy_eff; adv[i] = NOT vld[i] OR adv[i+1] for i < DEPTH-1.
REQ-018 Bubbles SHALL collapse: an empty stage always loads from its predecessor, even while downstream is blocked.
REQ-019 pc_ready_out SHALL equal adv[0] AND NOT stall_in AND NOT flush_in; the path is combinational with no registered skid.
REQ-020 On an edge with adv[i] = 1, stage i>0 SHALL load data[i-1] and vld[i-1]; stage 0 SHALL load pc_mux_in and (pc_valid_in AND pc_ready_out).
REQ-021 On an edge with adv[i] = 0, stage i SHALL hold data and valid.
REQ-022 Data registers SHALL NOT change on a load whose incoming valid is 0; only the valid bit is written.
REQ-023 An output transfer SHALL occur on an edge where pc_valid_out = 1 and rdy_eff = 1.
REQ-024 In an unblocked pipe, a beat accepted on edge E SHALL appear on pc_out with pc_valid_out = 1 after edge E+DEPTH-1; latency is DEPTH cycles.
REQ-025 With all stages valid and rdy_eff = 1 continuously, throughput SHALL be one beat per cycle.
REQ-026 flush_in = 1 SHALL clear all vld[i] on the next edge, accept no input beat and perform no output transfer; data registers hold.
REQ-027 flush_in SHALL take priority over stall_in and pc_valid_in on the same cycle.
REQ-028 stall_in = 1 with flush_in = 0 SHALL freeze every valid stage and hold pc_ready_out = 0; empty stages still collapse per REQ-018.
REQ-029 pc_count_out SHALL be a registered count equal to the popcount of vld after each edge, range 0..DEPTH, and SHALL never wrap.
REQ-030 Beat order SHALL be preserved; no beat is duplicated or dropped except by flush.

Reset
REQ-031 While ms_riscv32_mp_rst_n_in = 0, regardless of clock, data[i] SHALL be RESET_VECTOR, vld[i] = 0 and pc_count_out = 0.
REQ-032 During reset, pc_out SHALL equal RESET_VECTOR and pc_valid_out = 0; pc_ready_out follows REQ-019 from the reset state.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats immediately; the first edge after deassertion SHALL behave as an empty pipe.

Verification
REQ-034 Reset release with DEPTH=2, RESET_VECTOR=32'h0000_1000 -> pc_out = 32'h0000_1000, pc_valid_out = 0, pc_count_out = 0.
REQ-035 Beats 0x0, 0x4, 0x8 on consecutive cycles, pc_ready_in = 1 -> pc_out = 0x0, 0x4, 0x8 with each beat 2 cycles after acceptance; pc_ready_out stays 1.
REQ-036 pc_ready_in = 0 with 0x10 then 0x14 sent -> count reaches 2 and pc_ready_out = 0; pc_ready_in = 1 -> 0x10 then 0x14 drain in order.
REQ-037 Pipe holds 0x20, 0x24; flush_in = 1 and stall_in = 1 on the same cycle -> next edge: pc_valid_out = 0, count = 0, input beat 0x28 not accepted.
REQ-038 stall_in = 1 for 3 cycles with pipe full and pc_ready_in = 1 -> pc_out holds value, count holds 2; stall release -> drain resumes.
REQ-039 Reset asserted between edges with count = 2 -> pc_valid_out drops to 0 without a clock edge and pc_out = RESET_VECTOR.

Source files
------------

// File: rtl/msrv32_pc_pipe_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pc_pipe_reg_if
//  Description : Handshake and data bundle for the PC pipeline register.
//                The upstream producer side (pc_mux_in, pc_valid_in,
//                pc_ready_out) and the downstream side (pc_out,
//                pc_valid_out, pc_ready_in) are grouped with the global
//                stall/flush controls and the occupancy count.
//                  slave  : view of the pipeline register itself
//                  master : view of the environment driving it
//  Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_pc_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] pc_mux_in;     // upstream PC beat
  logic              pc_valid_in;   // upstream beat valid
  logic              pc_ready_out;  // stage 0 accepts this cycle
  logic              pc_ready_in;   // downstream accepts output beat
  logic              stall_in;      // global hold request
  logic              flush_in;      // pipeline kill request
  logic [DATA_W-1:0] pc_out;        // last-stage data
  logic              pc_valid_out;  // last-stage valid
  logic [CNT_W-1:0]  pc_count_out;  // number of valid stages

  modport slave (
    input  pc_mux_in, pc_valid_in, pc_ready_in, stall_in, flush_in,
    output pc_ready_out, pc_out, pc_valid_out, pc_count_out
  );

  modport master (
    output pc_mux_in, pc_valid_in, pc_ready_in, stall_in, flush_in,
    input  pc_ready_out, pc_out, pc_valid_out, pc_count_out
  );
endinterface
`default_nettype wire

// File: rtl/msrv32_pc_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pc_pipe_reg
//  Description : DEPTH-stage valid/ready PC pipeline register with bubble
//                collapse, global stall and flush, and a registered count
//                of occupied stages.
//  Ports       : ms_riscv32_mp_clk_in   - clock, rising edge
//                ms_riscv32_mp_rst_n_in - asynchronous active-low reset
//                pc_if (slave)          - PC beat in/out handshake,
//                                         stall/flush, occupancy count
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_pc_pipe_reg #(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 2,
  parameter logic [DATA_W-1:0] RESET_VECTOR = '0
) (
  input  wire logic              ms_riscv32_mp_clk_in,
  input  wire logic              ms_riscv32_mp_rst_n_in,
  msrv32_pc_pipe_reg_if.slave    pc_if
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [DEPTH-1:0]             r_vld;
  logic [CNT_W-1:0]             r_cnt;

  logic                         w_rdy_eff;
  logic                         w_accept;
  logic [DEPTH-1:0]             w_adv;
  logic [DEPTH-1:0][DATA_W-1:0] w_din;
  logic [DEPTH-1:0]             w_vin;
  logic [DEPTH-1:0]             w_load;
  logic [DEPTH-1:0]             w_vld_nxt;
  logic [CNT_W-1:0]             w_cnt_nxt;

  assign w_rdy_eff = pc_if.pc_ready_in & ~pc_if.stall_in;

  // A stage advances unless it and every stage after it are valid and the
  // consumer is blocked. Evaluated as a suffix-AND from the output end so
  // there is no combinational chain on w_adv itself.
  always_comb begin
    logic w_full;
    w_full = 1'b1;
    w_adv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_full   = w_full & r_vld[i];
      w_adv[i] = w_rdy_eff | ~w_full;
    end
  end

  assign pc_if.pc_ready_out = w_adv[0] & ~pc_if.stall_in & ~pc_if.flush_in;
  assign w_accept           = pc_if.pc_valid_in & pc_if.pc_ready_out;

  // Per-stage incoming data/valid: stage 0 from upstream, others from the
  // preceding stage.
  always_comb begin
    w_din    = '0;
    w_vin    = '0;
    w_din[0] = pc_if.pc_mux_in;
    w_vin[0] = w_accept;
    for (int i = 1; i < DEPTH; i++) begin
      w_din[i] = r_data[i-1];
      w_vin[i] = r_vld[i-1];
    end
  end

  // Data is written only when a valid beat actually lands; bubbles move
  // the valid bit alone. Flush clears valids and leaves data untouched.
  always_comb begin
    w_load    = '0;
    w_vld_nxt = '0;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_load[i]    = w_adv[i] & w_vin[i] & ~pc_if.flush_in;
      w_vld_nxt[i] = pc_if.flush_in ? 1'b0 : (w_adv[i] ? w_vin[i] : r_vld[i]);
      w_cnt_nxt    = w_cnt_nxt + CNT_W'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VECTOR;
      end
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_data[i] <= w_din[i];
        end
      end
      r_vld <= w_vld_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign pc_if.pc_out       = r_data[DEPTH-1];
  assign pc_if.pc_valid_out = r_vld[DEPTH-1];
  assign pc_if.pc_count_out = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_pc_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrv32_pc_pipe_reg
//  Description : Directed vector bench for msrv32_pc_pipe_reg with DEPTH=2
//                and RESET_VECTOR=32'h0000_1000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_pc_pipe_reg;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RV     = 32'h0000_1000;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  msrv32_pc_pipe_reg_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) pif ();

  msrv32_pc_pipe_reg #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .pc_if                  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [31:0] d;
    logic        rdy;
    logic        stall;
    logic        flush;
    logic        exp_rdy;
    logic [31:0] exp_pc;
    logic        exp_v;
    logic [1:0]  exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic vin, input logic [31:0] d,
                              input logic rdy, input logic stall,
                              input logic flush, input logic exp_rdy,
                              input logic [31:0] exp_pc, input logic exp_v,
                              input logic [1:0] exp_cnt);
    vec_t v;
    v.vin = vin; v.d = d; v.rdy = rdy; v.stall = stall; v.flush = flush;
    v.exp_rdy = exp_rdy; v.exp_pc = exp_pc; v.exp_v = exp_v; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, check combinational ready, take one
  // edge, then check the registered outputs.
  task automatic apply(input string tag, input vec_t v);
    pif.pc_valid_in = v.vin;
    pif.pc_mux_in   = v.d;
    pif.pc_ready_in = v.rdy;
    pif.stall_in    = v.stall;
    pif.flush_in    = v.flush;
    #2;
    check({tag, " ready"}, 32'(pif.pc_ready_out), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    check({tag, " pc_out"}, pif.pc_out, v.exp_pc);
    check({tag, " valid"}, 32'(pif.pc_valid_out), 32'(v.exp_v));
    check({tag, " count"}, 32'(pif.pc_count_out), 32'(v.exp_cnt));
  endtask

  vec_t vecs [24];

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //             vin d      rdy st fl  rdyo exp_pc  v  cnt
    // Streaming 0x0,0x4,0x8 at full rate
    vecs[0]  = mk(1, 32'h00, 1, 0, 0,  1, RV,     0, 1);
    vecs[1]  = mk(1, 32'h04, 1, 0, 0,  1, 32'h00, 1, 2);
    vecs[2]  = mk(1, 32'h08, 1, 0, 0,  1, 32'h04, 1, 2);
    vecs[3]  = mk(0, 32'h0C, 1, 0, 0,  1, 32'h08, 1, 1);
    vecs[4]  = mk(0, 32'h0C, 1, 0, 0,  1, 32'h08, 0, 0);
    // Backpressure fill, then in-order drain
    vecs[5]  = mk(1, 32'h10, 0, 0, 0,  1, 32'h08, 0, 1);
    vecs[6]  = mk(1, 32'h14, 0, 0, 0,  1, 32'h10, 1, 2);
    vecs[7]  = mk(1, 32'h18, 0, 0, 0,  0, 32'h10, 1, 2);
    vecs[8]  = mk(0, 32'h18, 1, 0, 0,  1, 32'h14, 1, 1);
    vecs[9]  = mk(0, 32'h18, 1, 0, 0,  1, 32'h14, 0, 0);
    // Flush with simultaneous stall and offered beat
    vecs[10] = mk(1, 32'h20, 0, 0, 0,  1, 32'h14, 0, 1);
    vecs[11] = mk(1, 32'h24, 0, 0, 0,  1, 32'h20, 1, 2);
    vecs[12] = mk(1, 32'h28, 1, 1, 1,  0, 32'h20, 0, 0);
    vecs[13] = mk(0, 32'h28, 1, 0, 0,  1, 32'h20, 0, 0);
    // Three-cycle stall on a full pipe, then resume
    vecs[14] = mk(1, 32'h30, 0, 0, 0,  1, 32'h20, 0, 1);
    vecs[15] = mk(1, 32'h34, 0, 0, 0,  1, 32'h30, 1, 2);
    vecs[16] = mk(1, 32'h38, 1, 1, 0,  0, 32'h30, 1, 2);
    vecs[17] = mk(1, 32'h38, 1, 1, 0,  0, 32'h30, 1, 2);
    vecs[18] = mk(1, 32'h38, 1, 1, 0,  0, 32'h30, 1, 2);
    vecs[19] = mk(0, 32'h38, 1, 0, 0,  1, 32'h34, 1, 1);
    vecs[20] = mk(0, 32'h38, 1, 0, 0,  1, 32'h34, 0, 0);
    // Bubble collapse while stalled: 0x40 moves up, 0x44 refused
    vecs[21] = mk(1, 32'h40, 0, 0, 0,  1, 32'h34, 0, 1);
    vecs[22] = mk(1, 32'h44, 1, 1, 0,  0, 32'h40, 1, 1);
    vecs[23] = mk(0, 32'h44, 1, 0, 0,  1, 32'h40, 0, 0);

    rst_n           = 1'b0;
    pif.pc_valid_in = 1'b0;
    pif.pc_mux_in   = '0;
    pif.pc_ready_in = 1'b0;
    pif.stall_in    = 1'b0;
    pif.flush_in    = 1'b0;

    // Held in reset across two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst pc_out", pif.pc_out, RV);
    check("rst valid", 32'(pif.pc_valid_out), 32'd0);
    check("rst count", 32'(pif.pc_count_out), 32'd0);
    check("rst ready", 32'(pif.pc_ready_out), 32'd1);

    rst_n = 1'b1;
    #1;
    check("release pc_out", pif.pc_out, RV);
    check("release valid", 32'(pif.pc_valid_out), 32'd0);
    check("release count", 32'(pif.pc_count_out), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset between edges with the pipe full
    apply("pre_rst0", mk(1, 32'h50, 0, 0, 0, 1, 32'h40, 0, 1));
    apply("pre_rst1", mk(1, 32'h54, 0, 0, 0, 1, 32'h50, 1, 2));
    pif.pc_valid_in = 1'b0;
    pif.pc_ready_in = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst valid", 32'(pif.pc_valid_out), 32'd0);
    check("async_rst pc_out", pif.pc_out, RV);
    check("async_rst count", 32'(pif.pc_count_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First edges after release behave as an empty pipe
    apply("post_rst0", mk(1, 32'h60, 1, 0, 0, 1, RV,     0, 1));
    apply("post_rst1", mk(0, 32'h60, 1, 0, 0, 1, 32'h60, 1, 1));
    apply("post_rst2", mk(0, 32'h60, 1, 0, 0, 1, 32'h60, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
